// File: rtl/apb_ram_wait.sv
// apb_ram_wait -- parametrised APB3 slave scratch RAM with programmable
// access-phase wait states and byte-address decode.
//
// Optional feature macro: APB_RAM_PSTRB_EN
//   defined   : pstrb port present, byte-lane write enables, and a read
//               with any strobe set returns an error.
//   undefined : no pstrb port, every write updates the full word.
//
// Ports:
//   pclk     in   clock, rising edge
//   presetn  in   asynchronous active-low reset
//   psel     in   slave select
//   penable  in   access-phase strobe
//   pwrite   in   1 = write, 0 = read
//   paddr    in   [ADDR_WIDTH]   byte address
//   pwdata   in   [DATA_WIDTH]   write data
//   pstrb    in   [DATA_WIDTH/8] byte-lane strobes (APB_RAM_PSTRB_EN only)
//   prdata   out  [DATA_WIDTH]   read data, valid while pready=1
//   pready   out  registered transfer completion
//   pslverr  out  error response, valid while pready=1
module apb_ram_wait #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
`ifdef APB_RAM_PSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] pstrb,
`endif
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned BL     = $clog2(NBYTES);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  pready_q;
  logic                  pslverr_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [IDX_W-1:0]      idx;
  logic                  acc_err;
  logic                  do_access;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Memory spans exactly 2^(BL+IDX_W) bytes, so any address bit at or above
  // that position means out of range (no aliasing onto low words).
  always_comb begin
    idx     = paddr[BL +: IDX_W];
    acc_err = (|(paddr & ALIGN_MASK)) || (|(paddr >> (BL + IDX_W)));
`ifdef APB_RAM_PSTRB_EN
    if (!pwrite && (|pstrb)) acc_err = 1'b1;
`endif
  end

`ifdef APB_RAM_PSTRB_EN
  always_comb begin
    mem_wdata = mem_q[idx];
    for (int unsigned b = 0; b < NBYTES; b++) begin
      if (pstrb[b]) mem_wdata[8*b +: 8] = pwdata[8*b +: 8];
    end
  end
`else
  always_comb begin
    mem_wdata = pwdata;
  end
`endif

  // Must match the FSM edges below that move into S_RESP.
  always_comb begin
    do_access = 1'b0;
    if (state_q == S_IDLE && psel && !penable && WAIT_STATES == 0)
      do_access = 1'b1;
    if (state_q == S_WAIT && psel && penable && cnt_q == 4'd1)
      do_access = 1'b1;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          if (psel && !penable) begin
            if (WAIT_STATES == 0) begin
              state_q  <= S_RESP;
              pready_q <= 1'b1;
            end else begin
              cnt_q   <= 4'(WAIT_STATES);
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (psel && penable) begin
            if (cnt_q == 4'd1) begin
              state_q  <= S_RESP;
              pready_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RESP: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase

      // Placed after the case so the access result overrides its pslverr clear.
      if (do_access) begin
        if (acc_err) begin
          prdata_q  <= '0;
          pslverr_q <= 1'b1;
        end else begin
          pslverr_q <= 1'b0;
          if (pwrite) mem_q[idx] <= mem_wdata;
          else        prdata_q   <= mem_q[idx];
        end
      end
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_ram_wait.sv
// Directed bench for apb_ram_wait: three instances (WAIT_STATES 0/3/4) on a
// shared bus, psel steered to one instance at a time by tgt_sel.
module tb_apb_ram_wait;

  logic        pclk;
  logic        presetn;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  int          tgt_sel;
  logic        psel0, psel1, psel2;
  logic [31:0] prdata0, prdata1, prdata2;
  logic        pready0, pready1, pready2;
  logic        pslverr0, pslverr1, pslverr2;
  logic [31:0] cur_rd;
  logic        cur_rdy, cur_err;
`ifdef APB_RAM_PSTRB_EN
  logic [3:0]  pstrb;
  logic [3:0]  strb_drv;
  logic [3:0]  rd_strb;
`endif

  int total = 0;
  int bad   = 0;

  assign psel0 = psel && (tgt_sel == 0);
  assign psel1 = psel && (tgt_sel == 1);
  assign psel2 = psel && (tgt_sel == 2);

  always_comb begin
    cur_rd  = prdata0;
    cur_rdy = pready0;
    cur_err = pslverr0;
    case (tgt_sel)
      1: begin cur_rd = prdata1; cur_rdy = pready1; cur_err = pslverr1; end
      2: begin cur_rd = prdata2; cur_rdy = pready2; cur_err = pslverr2; end
      default: ;
    endcase
  end

  apb_ram_wait #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32), .WAIT_STATES(0)) u_ws0 (
    .pclk(pclk), .presetn(presetn), .psel(psel0), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
`ifdef APB_RAM_PSTRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0));

  apb_ram_wait #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32), .WAIT_STATES(3)) u_ws3 (
    .pclk(pclk), .presetn(presetn), .psel(psel1), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
`ifdef APB_RAM_PSTRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prdata1), .pready(pready1), .pslverr(pslverr1));

  apb_ram_wait #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(32), .WAIT_STATES(4)) u_ws4 (
    .pclk(pclk), .presetn(presetn), .psel(psel2), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
`ifdef APB_RAM_PSTRB_EN
    .pstrb(pstrb),
`endif
    .prdata(prdata2), .pready(pready2), .pslverr(pslverr2));

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Starts one cycle after a rising edge (+1); returns the same way, with
  // the bus idle, so consecutive calls are back-to-back.
  task automatic xfer(input int tgt, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd,
                      input bit chk_rd, input bit exp_err, input int exp_lat,
                      input string nm);
    int k;
    tgt_sel = tgt;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
`ifdef APB_RAM_PSTRB_EN
    pstrb   = wr ? strb_drv : rd_strb;
`endif
    chk({nm, "_setup_rdy"}, {31'd0, cur_rdy}, 32'd0);
    @(posedge pclk); #1;
    penable = 1'b1;
    k = 0;
    while (!cur_rdy && k < 20) begin
      @(posedge pclk); #1;
      k++;
    end
    chk({nm, "_rdy"}, {31'd0, cur_rdy}, 32'd1);
    chk({nm, "_lat"}, k, exp_lat);
    chk({nm, "_err"}, {31'd0, cur_err}, {31'd0, exp_err});
    if (chk_rd) chk({nm, "_rd"}, cur_rd, exp_rd);
    @(posedge pclk); #1;
    psel    = 1'b0;
    penable = 1'b0;
    chk({nm, "_rdy_drop"}, {31'd0, cur_rdy}, 32'd0);
  endtask

  typedef struct {
    int          tgt;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          chk_rd;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[17];
  logic seen;

  initial begin
    //            tgt wr    addr          wdata         exp_rd        chk   err   lat
    vecs[0]  = '{0, 1'b0, 32'h0000_0000, 32'h0,        32'h0000_0000, 1'b1, 1'b0, 0};
    vecs[1]  = '{0, 1'b0, 32'h0000_007C, 32'h0,        32'h0000_0000, 1'b1, 1'b0, 0};
    vecs[2]  = '{0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 32'h0000_0000, 1'b1, 1'b0, 0};
    vecs[3]  = '{0, 1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 0};
    vecs[4]  = '{0, 1'b1, 32'h0000_007C, 32'hCAFEF00D, 32'hDEADBEEF, 1'b1, 1'b0, 0};
    vecs[5]  = '{0, 1'b0, 32'h0000_007C, 32'h0,        32'hCAFEF00D, 1'b1, 1'b0, 0};
    vecs[6]  = '{0, 1'b1, 32'h0000_0080, 32'hAAAAAAAA, 32'h0000_0000, 1'b1, 1'b1, 0};
    vecs[7]  = '{0, 1'b0, 32'h0000_0000, 32'h0,        32'h0000_0000, 1'b1, 1'b0, 0};
    vecs[8]  = '{0, 1'b1, 32'h0000_0006, 32'h11111111, 32'h0000_0000, 1'b1, 1'b1, 0};
    vecs[9]  = '{0, 1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 0};
    vecs[10] = '{0, 1'b0, 32'h0000_0006, 32'h0,        32'h0000_0000, 1'b1, 1'b1, 0};
    vecs[11] = '{0, 1'b0, 32'h0000_0004, 32'h0,        32'h0000_0000, 1'b1, 1'b0, 0};
    vecs[12] = '{0, 1'b0, 32'hFFFF_FFFC, 32'h0,        32'h0000_0000, 1'b1, 1'b1, 0};
    vecs[13] = '{1, 1'b1, 32'h0000_0004, 32'h12345678, 32'h0000_0000, 1'b0, 1'b0, 3};
    vecs[14] = '{1, 1'b0, 32'h0000_0004, 32'h0,        32'h12345678, 1'b1, 1'b0, 3};
    vecs[15] = '{1, 1'b0, 32'h0000_0080, 32'h0,        32'h0000_0000, 1'b1, 1'b1, 3};
    vecs[16] = '{1, 1'b0, 32'h0000_0010, 32'h0,        32'h0000_0000, 1'b1, 1'b0, 3};

    presetn = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    tgt_sel = 0;
`ifdef APB_RAM_PSTRB_EN
    pstrb    = 4'h0;
    strb_drv = 4'hF;
    rd_strb  = 4'h0;
`endif
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_rdy0", {31'd0, pready0}, 32'd0);
    chk("rst_rdy1", {31'd0, pready1}, 32'd0);
    chk("rst_rdy2", {31'd0, pready2}, 32'd0);
    chk("rst_err0", {31'd0, pslverr0}, 32'd0);
    chk("rst_rd0", prdata0, 32'd0);
    chk("rst_rd1", prdata1, 32'd0);
    chk("rst_rd2", prdata2, 32'd0);
    presetn = 1'b1;
    @(posedge pclk); #1;

    // psel+penable without a setup phase must be ignored (no write to 0x00).
    tgt_sel = 0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
    paddr = 32'h0; pwdata = 32'h5555_5555;
    seen = 1'b0;
    repeat (3) begin @(posedge pclk); #1; seen |= cur_rdy; end
    chk("idle_access_ignored", {31'd0, seen}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;

    for (int i = 0; i < 17; i++)
      xfer(vecs[i].tgt, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd,
           vecs[i].chk_rd, vecs[i].exp_err, vecs[i].exp_lat, $sformatf("v%0d", i));

    // WS=4: psel dropped in the 2nd access cycle aborts the write.
    tgt_sel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h08; pwdata = 32'hAAAA_5555;
    @(posedge pclk); #1; penable = 1'b1;
    @(posedge pclk); #1; psel = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(posedge pclk); #1; seen |= cur_rdy; end
    chk("abort_no_rdy", {31'd0, seen}, 32'd0);
    penable = 1'b0;
    @(posedge pclk); #1;
    xfer(2, 1'b0, 32'h08, 32'h0, 32'h0, 1'b1, 1'b0, 4, "abort_mem");

    // WS=4: reset during WAIT abandons the write and clears everything.
    xfer(2, 1'b1, 32'h0C, 32'h5A5A_5A5A, 32'h0, 1'b0, 1'b0, 4, "ws4_wr");
    xfer(2, 1'b0, 32'h0C, 32'h0, 32'h5A5A_5A5A, 1'b1, 1'b0, 4, "ws4_rd");
    tgt_sel = 2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h0C; pwdata = 32'h0F0F_0F0F;
    @(posedge pclk); #1; penable = 1'b1;
    @(posedge pclk); #1;
    presetn = 1'b0;
    #1;
    chk("midrst_rdy", {31'd0, pready2}, 32'd0);
    chk("midrst_err", {31'd0, pslverr2}, 32'd0);
    chk("midrst_rd2", prdata2, 32'd0);
    chk("midrst_rd0", prdata0, 32'd0);
    chk("midrst_rd1", prdata1, 32'd0);
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    presetn = 1'b1;
    @(posedge pclk); #1;
    xfer(2, 1'b0, 32'h0C, 32'h0, 32'h0, 1'b1, 1'b0, 4, "postrst_ws4");
    xfer(0, 1'b0, 32'h7C, 32'h0, 32'h0, 1'b1, 1'b0, 0, "postrst_ws0");
    xfer(1, 1'b0, 32'h04, 32'h0, 32'h0, 1'b1, 1'b0, 3, "postrst_ws3");

`ifdef APB_RAM_PSTRB_EN
    strb_drv = 4'b0101;
    xfer(0, 1'b1, 32'h00, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 0, "strb_wr");
    strb_drv = 4'b0000;
    xfer(0, 1'b1, 32'h00, 32'h1111_1111, 32'h0, 1'b0, 1'b0, 0, "strb_none");
    xfer(0, 1'b0, 32'h00, 32'h0, 32'h00FF_00FF, 1'b1, 1'b0, 0, "strb_rd");
    rd_strb = 4'b0001;
    xfer(0, 1'b0, 32'h00, 32'h0, 32'h0, 1'b1, 1'b1, 0, "strb_rd_err");
    rd_strb  = 4'b0000;
    strb_drv = 4'hF;
`endif

    repeat (2) @(posedge pclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_ram_wait.md
Name: apb_ram_wait

Overview:
- Parametrised APB3 slave RAM; successor to the fixed 32x32 zero-wait slave RAM.
- Data width, depth and access wait states are configurable.
- Address decode is byte-based, with alignment and range error reporting.
- Sits on the APB bus as a memory-mapped scratch RAM and is the DUT for the APB UVM environment.

Parameters:
- DATA_WIDTH, 32, bus/word width in bits; one of 8, 16, 32, 64.
- ADDR_WIDTH, 32, paddr width.
- DEPTH, 32, number of words; power of 2, at least 2.
- WAIT_STATES, 0, extra access-phase cycles before pready; 0 to 15.

Ports:
- pclk  in  1  clock, rising edge.
- presetn  in  1  asynchronous active-low reset.
- psel  in  1  slave select.
- penable  in  1  access-phase strobe.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  byte-lane strobes; present only with APB_RAM_PSTRB_EN.
- prdata  out  DATA_WIDTH  read data, valid while pready=1.
- pready  out  1  transfer completion, registered.
- pslverr  out  1  error response, valid only while pready=1.

Behaviour:
- Reset (presetn=0, async): state=IDLE, pready=0, pslverr=0, prdata=0, every memory word=0.
- Reset mid-transfer abandons the transfer; no memory write occurs.
- Decode:
  - BL = log2(DATA_WIDTH/8).
  - Word index = paddr[BL +: log2(DEPTH)].
  - Error if paddr[BL-1:0] != 0 (misaligned), or if paddr >= DEPTH*DATA_WIDTH/8 (out of range).
- IDLE:
  - pready=0, pslverr=0.
  - On an edge with psel=1 and penable=0 (setup phase):
    - WAIT_STATES=0: perform access, go to RESP.
    - Otherwise: load cnt=WAIT_STATES, go to WAIT.
  - psel=1 with penable=1 in IDLE is ignored and the state stays IDLE.
- WAIT:
  - Each edge with psel=1 and penable=1 decrements cnt.
  - When cnt==1 at an edge: perform access, go to RESP.
  - psel=0, or penable=0, at any edge: abort to IDLE; no write, no response.
- Perform access (registered, same edge that sets pready<=1):
  - Valid write: mem[idx]<=pwdata; pslverr<=0.
  - Valid read: prdata<=mem[idx]; pslverr<=0.
  - Error: no memory update; prdata<=0; pslverr<=1.
- RESP:
  - pready=1 for exactly one cycle.
  - Next edge: pready<=0, pslverr<=0, go to IDLE.
  - prdata holds its value until the next read completes.
- Latency: pready is high in access cycle T+WAIT_STATES, where T is the first cycle with penable=1.
- Back-to-back: a setup phase in the cycle after RESP is accepted with no idle gap.
- Reads of a word written in the previous transfer return the new data.
- Unreachable state encodings recover to IDLE.

Optional Feature:
- APB_RAM_PSTRB_EN defined:
  - pstrb port exists.
  - Writes update only byte lanes with pstrb[i]=1; pstrb=0 writes nothing but completes with pslverr=0.
  - A read with pstrb!=0 is an error: pslverr=1, prdata=0.
- APB_RAM_PSTRB_EN undefined: no pstrb port; every write updates all lanes.

Test Plan:
- Reset, then read addr 0x00 and 0x7C (DW=32, DEPTH=32, WS=0) -> prdata=0, pslverr=0, pready high in first access cycle.
- WS=0: write 0xDEADBEEF to 0x10, read 0x10 back-to-back -> prdata=0xDEADBEEF, each transfer 2 cycles, no gap between transfers.
- WS=3: write 0x12345678 to 0x04 -> pready rises on 4th access cycle; penable held 4 cycles; read returns 0x12345678.
- Error responses, both with pready=1, prdata=0 and memory unchanged:
  - Write to 0x80 (out of range).
  - Read from 0x06 (misaligned).
- WS=4: drop psel in 2nd access cycle of a write 0xAAAA5555 to 0x08 -> no pready, memory at 0x08 unchanged.
- Assert presetn=0 mid-WAIT -> pready=0 and pslverr=0 immediately; memory cleared.
- With APB_RAM_PSTRB_EN: write 0xFFFFFFFF with pstrb=4'b0101 over 0x00000000 -> read gives 0x00FF00FF.
